// File: rtl/char_buffer_ctrl.sv
// char_buffer_ctrl: character RAM with round-robin two-writer port, vblank clear engine and registered read
// Ports: clk/rst (sync, active-high); vblank_in, clear_req start a frame-synchronised fill;
//   wr0_*/wr1_* req/addr/code in, ack out (one-cycle pulse); rd_addr in, rd_code out (1-cycle latency);
//   busy (clear pending or running), text_en (low while clearing).
module char_buffer_ctrl #(
  parameter int ADDR_W = 8,
  parameter int CODE_W = 7,
  parameter logic [CODE_W-1:0] FILL_CODE = 7'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vblank_in,
  input  logic              clear_req,
  input  logic              wr0_req,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [CODE_W-1:0] wr0_code,
  output logic              wr0_ack,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [CODE_W-1:0] wr1_code,
  output logic              wr1_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CODE_W-1:0] rd_code,
  output logic              busy,
  output logic              text_en
);
  typedef enum logic [1:0] {IDLE, WAIT_VB, CLEAR} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              rr_last_q, rr_last_d;
  logic              wr0_ack_q, wr0_ack_d;
  logic              wr1_ack_q, wr1_ack_d;
  logic [CODE_W-1:0] rd_code_q;
  logic [CODE_W-1:0] mem [1 << ADDR_W];
  logic              e0, e1, g0, g1, we;
  logic [ADDR_W-1:0] waddr;
  logic [CODE_W-1:0] wdata;
  always_comb begin
    // a port is masked during its own ack cycle so a held req is not granted twice
    e0 = state_q == IDLE && wr0_req && !wr0_ack_q;
    e1 = state_q == IDLE && wr1_req && !wr1_ack_q;
    g0 = e0 && (!e1 || rr_last_q);
    g1 = e1 && (!e0 || !rr_last_q);
    state_d = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == IDLE && clear_req) state_d = WAIT_VB;
    if (state_q == WAIT_VB && vblank_in) begin
      state_d = CLEAR;
      clr_addr_d = '0;
    end
    if (state_q == CLEAR) begin
      clr_addr_d = clr_addr_q + ADDR_W'(1);
      if (&clr_addr_q) state_d = IDLE;
    end
    rr_last_d = g0 ? 1'b0 : g1 ? 1'b1 : rr_last_q;
    wr0_ack_d = g0;
    wr1_ack_d = g1;
    we = g0 || g1 || state_q == CLEAR;
    waddr = state_q == CLEAR ? clr_addr_q : g1 ? wr1_addr : wr0_addr;
    wdata = state_q == CLEAR ? FILL_CODE : g1 ? wr1_code : wr0_code;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      clr_addr_q <= '0;
      rr_last_q <= 1'b1;
      wr0_ack_q <= 1'b0;
      wr1_ack_q <= 1'b0;
      rd_code_q <= '0;
    end else begin
      state_q <= state_d;
      clr_addr_q <= clr_addr_d;
      rr_last_q <= rr_last_d;
      wr0_ack_q <= wr0_ack_d;
      wr1_ack_q <= wr1_ack_d;
      rd_code_q <= mem[rd_addr];
    end
  end
  // RAM has no reset; a reset edge commits nothing, leaving a partial clear as-is
  always_ff @(posedge clk) begin
    if (we && !rst) mem[waddr] <= wdata;
  end
  assign wr0_ack = wr0_ack_q;
  assign wr1_ack = wr1_ack_q;
  assign rd_code = rd_code_q;
  assign busy    = state_q != IDLE;
  assign text_en = state_q != CLEAR;
endmodule
